// File: rtl/crosscorr_mul_pkg.sv
// Shared types and elaboration constants for the cross-correlation multiplier pipeline.
package crosscorr_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 8;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    // Full product width: each operand gains one extension bit before the signed multiply.
    function automatic int prod_width(input int din0_w, input int din1_w);
        return din0_w + din1_w + 2;
    endfunction

    function automatic logic ext_bit(input mul_mode_e mode, input logic msb);
        return (mode == MUL_SIGNED) && msb;
    endfunction

endpackage

// File: rtl/crosscorr_mul_stage.sv
// One valid/data/tag pipeline register. It loads when empty or when the next stage
// takes its contents, so bubbles collapse instead of stalling the whole pipe.
module crosscorr_mul_stage
    import crosscorr_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 54,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic [TAG_WIDTH-1:0]  up_tag,
    input  logic                  down_load,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TAG_WIDTH-1:0]  tag
);

    logic load;

    assign load = !valid || down_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= up_valid;
            // Payload only moves with a real item so an idle output keeps its last value.
            if (up_valid) begin
                data <= up_data;
                tag  <= up_tag;
            end
        end
    end

endmodule

// File: rtl/crosscorr_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and a pass-through tag.
// Optional macro CROSSCORR_MUL_ROUND_EN: round half up at the SHIFT position instead of truncating.
module crosscorr_mul_pipe
    import crosscorr_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 26,
    parameter int DIN1_WIDTH = 26,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0,
    parameter int DOUT_WIDTH = 52,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_signed,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int PROD_W = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int EXT_W  = PROD_W + DOUT_WIDTH;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
        $error("crosscorr_mul_pipe: NUM_STAGE must be within 1..8");
    end
    if (SHIFT < 0 || SHIFT + DOUT_WIDTH > PROD_W + DOUT_WIDTH) begin : g_bad_shift
        $error("crosscorr_mul_pipe: SHIFT+DOUT_WIDTH exceeds the extended product width");
    end

`ifdef CROSSCORR_MUL_ROUND_EN
    localparam logic [PROD_W-1:0] ROUND_C =
        (SHIFT > 0) ? (PROD_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic [PROD_W-1:0] ROUND_C = '0;
`endif

    mul_mode_e          mode;
    logic [PROD_W-1:0]  a_ext;
    logic [PROD_W-1:0]  b_ext;
    logic [PROD_W-1:0]  prod;

    assign mode  = in_signed ? MUL_SIGNED : MUL_UNSIGNED;
    assign a_ext = {{(PROD_W - DIN0_WIDTH){ext_bit(mode, din0[DIN0_WIDTH-1])}}, din0};
    assign b_ext = {{(PROD_W - DIN1_WIDTH){ext_bit(mode, din1[DIN1_WIDTH-1])}}, din1};
    // Both operands are already sign-extended to PROD_W, so the low PROD_W bits are the signed product.
    assign prod  = a_ext * b_ext;

    logic [NUM_STAGE-1:0]                 st_valid;
    logic [NUM_STAGE-1:0]                 down_load;
    logic [NUM_STAGE-1:0][PROD_W-1:0]     st_data;
    logic [NUM_STAGE-1:0][TAG_WIDTH-1:0]  st_tag;

    // Stage i+1 loads when out_ready or any stage from i+1 to the output is empty;
    // computed flat from the valid bits rather than chained through each stage.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        down_load = '0;
        for (int i = NUM_STAGE - 1; i >= 0; i--) begin
            down_load[i] = out_ready || !tail_full;
            tail_full    = tail_full && st_valid[i];
        end
    end

    assign in_ready = !st_valid[0] || down_load[0];

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        localparam logic [PROD_W-1:0] ADD_C = (i == NUM_STAGE - 1) ? ROUND_C : '0;

        logic                 up_valid;
        logic [PROD_W-1:0]    base_data;
        logic [PROD_W-1:0]    up_data;
        logic [TAG_WIDTH-1:0] up_tag;

        if (i == 0) begin : g_first
            assign up_valid  = in_valid;
            assign base_data = prod;
            assign up_tag    = in_tag;
        end else begin : g_next
            assign up_valid  = st_valid[i-1];
            assign base_data = st_data[i-1];
            assign up_tag    = st_tag[i-1];
        end

        assign up_data = base_data + ADD_C;

        crosscorr_mul_stage #(
            .DATA_WIDTH (PROD_W),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_stage (
            .clk       (ap_clk),
            .rst       (ap_rst),
            .up_valid  (up_valid),
            .up_data   (up_data),
            .up_tag    (up_tag),
            .down_load (down_load[i]),
            .valid     (st_valid[i]),
            .data      (st_data[i]),
            .tag       (st_tag[i])
        );
    end

    logic [EXT_W-1:0] prod_ext;

    assign prod_ext  = {{DOUT_WIDTH{st_data[NUM_STAGE-1][PROD_W-1]}}, st_data[NUM_STAGE-1]};
    assign dout      = DOUT_WIDTH'(prod_ext >> SHIFT);
    assign out_valid = st_valid[NUM_STAGE-1];
    assign out_tag   = st_tag[NUM_STAGE-1];

endmodule
